// File: rtl/wb_dma_copy_pkg.sv
// Shared Wishbone constants and DMA copy FSM state encoding.
package zeitlos_wb_pkg;

  localparam int unsigned WB_ADR_W = 30;
  localparam int unsigned WB_DAT_W = 32;
  localparam logic [3:0]  WB_SEL_ALL = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/wb_dma_copy_if.sv
// Wishbone classic master-side bus bundle used by the DMA copy engine.
interface wb_dma_copy_if;
  import zeitlos_wb_pkg::*;

  logic [WB_ADR_W-1:0] m_wb_adr_o;
  logic [WB_DAT_W-1:0] m_wb_dat_o;
  logic [WB_DAT_W-1:0] m_wb_dat_i;
  logic                m_wb_we_o;
  logic [3:0]          m_wb_sel_o;
  logic                m_wb_stb_o;
  logic                m_wb_cyc_o;
  logic                m_wb_ack_i;

  modport master (
    output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
    output m_wb_dat_i, m_wb_ack_i
  );

endinterface

// File: rtl/wb_dma_copy_timeout.sv
// Per-transaction ack watchdog: counts enabled cycles, flags when the limit is hit.
module wb_ack_timeout #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Gated by i_en so a same-cycle ack always takes priority over expiry.
  assign o_expired = i_en && (r_cnt == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone classic initiator that copies (read-then-write) or fills a block of words.
module wb_dma_copy
  import zeitlos_wb_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [WB_ADR_W-1:0] src_i,
  input  logic [WB_ADR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [WB_DAT_W-1:0] pattern_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  wb_dma_copy_if.master       m_wb
);

  dma_state_t          r_state, w_next;
  logic [WB_ADR_W-1:0] r_src, r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [WB_DAT_W-1:0] r_pat, r_data;
  logic                r_mode, r_err;
  logic                w_bus, w_ack, w_expired, w_to_clr, w_to_en, w_last;

  assign w_bus    = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_ack    = w_bus && m_wb.m_wb_ack_i;
  assign w_to_clr = !w_bus || w_ack;
  assign w_to_en  = w_bus && !w_ack;
  assign w_last   = (r_len == {{(LEN_W-1){1'b0}}, 1'b1});

  wb_ack_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .i_clr      (w_to_clr),
    .i_en       (w_to_en),
    .o_expired  (w_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) begin
                 if (len_i == '0) w_next = ST_DONE;
                 else             w_next = mode_i ? ST_WR : ST_RD;
               end
      ST_RD:   if (w_ack)          w_next = ST_WR;
               else if (w_expired) w_next = ST_DONE;
      ST_WR:   if (w_ack)          w_next = w_last ? ST_DONE : ST_GAP;
               else if (w_expired) w_next = ST_DONE;
      ST_GAP:  w_next = r_mode ? ST_WR : ST_RD;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_len  <= '0;
      r_pat  <= '0;
      r_data <= '0;
      r_mode <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start_i) begin
        r_src  <= src_i;
        r_dst  <= dst_i;
        r_len  <= len_i;
        r_pat  <= pattern_i;
        r_mode <= mode_i;
        r_err  <= 1'b0;
      end
      if ((r_state == ST_RD) && w_ack) r_data <= m_wb.m_wb_dat_i;
      if ((r_state == ST_WR) && w_ack) begin
        r_src <= r_src + 30'd1;
        r_dst <= r_dst + 30'd1;
        r_len <= r_len - {{(LEN_W-1){1'b0}}, 1'b1};
      end
      if (w_expired) r_err <= 1'b1;
    end
  end

  // Bus outputs decode straight from the state register so reset drops cyc/stb at once.
  assign m_wb.m_wb_cyc_o = w_bus;
  assign m_wb.m_wb_stb_o = w_bus;
  assign m_wb.m_wb_we_o  = (r_state == ST_WR);
  assign m_wb.m_wb_sel_o = WB_SEL_ALL;
  assign m_wb.m_wb_adr_o = (r_state == ST_RD) ? r_src : r_dst;
  assign m_wb.m_wb_dat_o = r_mode ? r_pat : r_data;

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);
  assign err_o  = r_err;

endmodule
